// File: rtl/hist_acq_sequencer_pkg.sv
// hist_pkg: shared types and helpers for the histogram acquisition sequencer.
//   hist_seq_state_t : sequencer FSM states
//   NOHIT_CODE       : all-ones "no photon" timestamp, sliced to the TDC width by users
//   idx_width        : index width for a count of n items, never less than 1 bit
//   cnt_width        : width of a counter that must hold the value n itself
package hist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } hist_seq_state_t;

  // Wider than any practical TDC; slice [NP-1:0] to get 2^NP-1.
  localparam logic [31:0] NOHIT_CODE = 32'hFFFF_FFFF;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/hist_acq_sequencer_if.sv
// hist_acq_sequencer_if: TDC timestamp handshake plus histogram-builder write port.
//   tdc_valid/tdc_data/tdc_ready : timestamp stream into the sequencer
//   hb_clr_n/hb_wrEn/hb_data     : builder clear and write port out of the sequencer
// master = timestamp source / builder side, slave = sequencer side.
interface hist_acq_sequencer_if #(
  parameter int unsigned NP = 10
) ();

  logic          tdc_valid;
  logic [NP-1:0] tdc_data;
  logic          tdc_ready;
  logic          hb_clr_n;
  logic          hb_wrEn;
  logic [NP-1:0] hb_data;

  modport master (
    output tdc_valid,
    output tdc_data,
    input  tdc_ready,
    input  hb_clr_n,
    input  hb_wrEn,
    input  hb_data
  );

  modport slave (
    input  tdc_valid,
    input  tdc_data,
    output tdc_ready,
    output hb_clr_n,
    output hb_wrEn,
    output hb_data
  );

endinterface

// File: rtl/hist_acq_sequencer_idx_counter.sv
// hist_idx_counter: nested pixel/acquisition counter.
//   clk, res (sync active-low), clr (sync zero), en (advance one pixel)
//   pixel_idx : wraps at PIXEL_NUM-1, carrying into acq_idx
//   acq_idx   : current acquisition
//   last      : both indices at their final values; en is then ignored so they hold
module hist_idx_counter
  import hist_pkg::*;
#(
  parameter int unsigned PIXEL_NUM = 6,
  parameter int unsigned ACQ_NUM   = 2
) (
  input  logic                            clk,
  input  logic                            res,
  input  logic                            clr,
  input  logic                            en,
  output logic [idx_width(PIXEL_NUM)-1:0] pixel_idx,
  output logic [idx_width(ACQ_NUM)-1:0]   acq_idx,
  output logic                            last
);

  localparam int unsigned PW = idx_width(PIXEL_NUM);
  localparam int unsigned AW = idx_width(ACQ_NUM);

  logic pix_wrap;
  logic acq_last;

  assign pix_wrap = (pixel_idx == PW'(PIXEL_NUM - 1));
  assign acq_last = (acq_idx == AW'(ACQ_NUM - 1));
  assign last     = pix_wrap & acq_last;

  always_ff @(posedge clk) begin
    if (!res || clr) begin
      pixel_idx <= '0;
      acq_idx   <= '0;
    end else if (en && !last) begin
      if (pix_wrap) begin
        pixel_idx <= '0;
        acq_idx   <= acq_idx + AW'(1);
      end else begin
        pixel_idx <= pixel_idx + PW'(1);
      end
    end
  end

endmodule

// File: rtl/hist_acq_sequencer.sv
// hist_acq_sequencer: front-end controller for the histogram builder.
// Clears the builder at frame start, forwards PIXEL_NUM*ACQ_NUM accepted TDC timestamps
// to the builder write port with one cycle of latency, waits DRAIN_CYCLES for the builder
// pipeline, then pulses frame_done.
//   clk, res (sync active-low), start, abort
//   bus        : slave side of hist_acq_sequencer_if (tdc handshake in, builder port out)
//   pixel_idx  : next pixel to be accepted; acq_idx : current acquisition
//   busy       : not IDLE; frame_done : one-cycle completion pulse
// Build option: define HIST_SEQ_NOHIT_FILTER_EN to drop all-ones "no photon" samples
// (still consumed and counted, but not written to the builder).
module hist_acq_sequencer
  import hist_pkg::*;
#(
  parameter int unsigned NP           = 10,
  parameter int unsigned PIXEL_NUM    = 6,
  parameter int unsigned ACQ_NUM      = 2,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            res,
  input  logic                            start,
  input  logic                            abort,
  hist_acq_sequencer_if.slave             bus,
  output logic [idx_width(PIXEL_NUM)-1:0] pixel_idx,
  output logic [idx_width(ACQ_NUM)-1:0]   acq_idx,
  output logic                            busy,
  output logic                            frame_done
);

  localparam int unsigned DW = cnt_width(DRAIN_CYCLES);

  hist_seq_state_t state_q, state_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            wr_q, wr_d;
  logic [NP-1:0]   data_q, data_d;

  logic accept;
  logic nohit;
  logic cnt_clr;
  logic cnt_en;
  logic idx_last;

  assign accept = bus.tdc_valid & bus.tdc_ready;

`ifdef HIST_SEQ_NOHIT_FILTER_EN
  assign nohit = (bus.tdc_data == NOHIT_CODE[NP-1:0]);
`else
  assign nohit = 1'b0;
`endif

  hist_idx_counter #(
    .PIXEL_NUM (PIXEL_NUM),
    .ACQ_NUM   (ACQ_NUM)
  ) u_idx_counter (
    .clk       (clk),
    .res       (res),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .pixel_idx (pixel_idx),
    .acq_idx   (acq_idx),
    .last      (idx_last)
  );

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= IDLE;
      drain_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    wr_d           = 1'b0;
    data_d         = data_q;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    bus.tdc_ready  = (state_q == RUN);
    bus.hb_clr_n   = (state_q != CLEAR);
    busy           = (state_q != IDLE);
    // Suppressed under abort so an aborted frame never reports completion.
    frame_done     = (state_q == DONE) && !abort;

    if (abort && (state_q != IDLE)) begin
      // Abort wins over start and over a same-cycle accept; that sample is dropped.
      state_d = IDLE;
      drain_d = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CLEAR;
            cnt_clr = 1'b1;
          end
        end
        CLEAR: state_d = RUN;
        RUN: begin
          if (accept) begin
            cnt_en = 1'b1;
            wr_d   = !nohit;
            if (!nohit) begin
              data_d = bus.tdc_data;
            end
            if (idx_last) begin
              state_d = DRAIN;
              drain_d = '0;
            end
          end
        end
        DRAIN: begin
          // The final write lands in the first DRAIN cycle, so counting starts there.
          if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
            state_d = DONE;
            drain_d = '0;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.hb_wrEn = wr_q;
  assign bus.hb_data = data_q;

endmodule

// File: tb/tb_hist_acq_sequencer.sv
// Self-checking bench for hist_acq_sequencer. A timeline model (frame phase, accepted
// sample count, cycles since the last accept) predicts every output each cycle.
module tb_hist_acq_sequencer;

  localparam int unsigned NP    = 10;
  localparam int unsigned PN    = 6;
  localparam int unsigned AN    = 2;
  localparam int unsigned D     = 4;
  localparam int          TOTAL = PN * AN;
`ifdef HIST_SEQ_NOHIT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res;
  logic       start;
  logic       abort;
  logic [2:0] pixel_idx;
  logic [0:0] acq_idx;
  logic       busy;
  logic       frame_done;

  hist_acq_sequencer_if #(.NP(NP)) bus ();

  hist_acq_sequencer #(
    .NP           (NP),
    .PIXEL_NUM    (PN),
    .ACQ_NUM      (AN),
    .DRAIN_CYCLES (D)
  ) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .abort      (abort),
    .bus        (bus),
    .pixel_idx  (pixel_idx),
    .acq_idx    (acq_idx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: ph 0=idle 1=clear 2=run 3=drain 4=done
  int            ph   = 0;
  int            acc  = 0;
  int            dcnt = 0;
  logic          m_wr = 1'b0;
  logic [NP-1:0] m_data = '0;
  bit            m_took = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int ep;
    int ea;
    ep = (acc == TOTAL) ? PN - 1 : acc % PN;
    ea = (acc == TOTAL) ? AN - 1 : acc / PN;
    chk("tdc_ready", 32'(bus.tdc_ready), 32'(ph == 2));
    chk("hb_clr_n", 32'(bus.hb_clr_n), 32'(ph != 1));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("frame_done", 32'(frame_done), 32'(ph == 4));
    chk("hb_wrEn", 32'(bus.hb_wrEn), 32'(m_wr));
    chk("hb_data", 32'(bus.hb_data), 32'(m_data));
    chk("pixel_idx", 32'(pixel_idx), 32'(ep));
    chk("acq_idx", 32'(acq_idx), 32'(ea));
  endtask

  // Advance the model with the inputs currently driven, clock once, then compare.
  task automatic cyc();
    bit take;
    take = 1'b0;
    if (!res) begin
      ph = 0; acc = 0; dcnt = 0; m_wr = 1'b0; m_data = '0;
    end else if (abort && ph != 0) begin
      ph = 0; acc = 0; m_wr = 1'b0;
    end else begin
      m_wr = 1'b0;
      case (ph)
        0: if (start) begin ph = 1; acc = 0; end
        1: ph = 2;
        2: begin
          if (bus.tdc_valid) begin
            take = 1'b1;
            acc++;
            if (!(FILT && bus.tdc_data == '1)) begin
              m_wr   = 1'b1;
              m_data = bus.tdc_data;
            end
            if (acc == TOTAL) begin ph = 3; dcnt = 0; end
          end
        end
        3: begin dcnt++; if (dcnt == D) ph = 4; end
        4: ph = 0;
        default: ph = 0;
      endcase
    end
    m_took = take;
    @(posedge clk);
    #1;
    check_all();
  endtask

  // One frame: gap_after = accepted count at which valid drops for 3 cycles,
  // abort_at = sample index carrying abort, nohit_at = sample replaced by all-ones.
  task automatic frame(input int gap_after, input int abort_at, input int nohit_at,
                       input bit rand_gaps, input bit stray_start, input bit rst_drain);
    logic [NP-1:0] smp [TOTAL];
    logic [NP-1:0] base [3];
    int k;
    int gap;
    base[0] = 10'd108; base[1] = 10'd511; base[2] = 10'd1022;
    for (int i = 0; i < TOTAL; i++) begin
      smp[i] = (i < 3) ? base[i] : NP'($urandom_range(0, 1022));
    end
    if (nohit_at >= 0) smp[nohit_at] = '1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    gap = 0;
    for (int c = 0; c < 200 && ph != 0; c++) begin
      bus.tdc_valid = (k < TOTAL);
      if (k == gap_after && gap < 3 && ph == 2) begin
        bus.tdc_valid = 1'b0;
        gap++;
      end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
        bus.tdc_valid = 1'b0;
      end
      abort = 1'b0;
      if (k == abort_at && ph == 2) begin
        bus.tdc_valid = 1'b1;
        abort = 1'b1;
      end
      bus.tdc_data = smp[(k < TOTAL) ? k : TOTAL - 1];
      start = stray_start && (ph == 4 || (ph == 2 && $urandom_range(0, 1) == 1));
      res = !(rst_drain && ph == 3 && dcnt == 1);
      cyc();
      if (m_took) k++;
    end
    bus.tdc_valid = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    res = 1'b1;
    cyc();
  endtask

  initial begin
    res = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus.tdc_valid = 1'b0;
    bus.tdc_data = '0;
    cyc();
    cyc();
    res = 1'b1;
    cyc();
    // Abort in IDLE is ignored.
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cyc();
    // Basic back-to-back frame.
    frame(-1, -1, -1, 1'b0, 1'b0, 1'b0);
    // Valid gap after the fourth sample.
    frame(4, -1, -1, 1'b0, 1'b0, 1'b0);
    // Abort together with the eighth sample, then a clean frame.
    frame(-1, 7, -1, 1'b0, 1'b0, 1'b0);
    frame(-1, -1, -1, 1'b0, 1'b0, 1'b0);
    // Stray starts during RUN and DONE, random gaps.
    frame(-1, -1, -1, 1'b1, 1'b1, 1'b0);
    // Reset during DRAIN.
    frame(-1, -1, -1, 1'b0, 1'b0, 1'b1);
    // All-ones timestamp as sample 3.
    frame(-1, -1, 2, 1'b0, 1'b0, 1'b0);
    frame(-1, -1, 5, 1'b1, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
